mult_seq_ctrl_8b: RTL

Sequential 8x8 unsigned shift-add multiplier built around one shared adder_8b instance (ports i0, i1, cin, cout, sum).
- Owns the control FSM, operand and partial-product registers, and the iteration counter.
- Uses the adder for one partial-sum addition per clock.
- Sits beside the ALU's combinational ops and produces a 16-bit product under a start/busy/done handshake.

---
 rtl/mult_seq_ctrl_8b.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl_8b.sv
// Sequential 8x8 unsigned shift-add multiplier around one shared adder_8b.
// Ports: clk, reset (sync, active-high), start, a[7:0], b[7:0] in;
//        busy, done (1-cycle strobe), product[15:0] out.
// Option: define MULT_ZERO_SKIP_EN to finish zero-operand ops without CALC.

module adder_8b (
  input  logic [7:0] i0,
  input  logic [7:0] i1,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] sum
);

  assign {cout, sum} = {1'b0, i0} + {1'b0, i1} + {8'd0, cin};

endmodule

module mult_seq_ctrl_8b (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [15:0] p_q, p_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        add_cout;
  logic [7:0]  add_sum;
  logic [15:0] p_shift;

  adder_8b u_adder (
    .i0   (p_q[15:8]),
    .i1   (a_q),
    .cin  (1'b0),
    .cout (add_cout),
    .sum  (add_sum)
  );

  // cout lands in P[15]; the product never exceeds 16 bits.
  always_comb begin
    if (p_q[0]) begin
      p_shift = {add_cout, add_sum, p_q[7:1]};
    end else begin
      p_shift = {1'b0, p_q[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= 8'd0;
      p_q       <= 16'd0;
      count_q   <= 4'd0;
      product_q <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      p_q       <= p_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    p_d       = p_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = a;
          p_d     = {8'd0, b};
          count_d = 4'd0;
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef MULT_ZERO_SKIP_EN
          if ((a == 8'd0) || (b == 8'd0)) begin
            product_d = 16'd0;
            done_d    = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end
      CALC: begin
        busy_d  = 1'b1;
        p_d     = p_shift;
        count_d = count_q + 4'd1;
        if (count_q == 4'd7) begin
          product_d = p_shift;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
